act_wb_arbiter: RTL and testbench
=================================

Name: act_wb_arbiter

Overview:
- Write-back controller for the activation memory write port, shared between two requesters.
- Requester 1: the accelerator output stream. It has no backpressure and can issue one beat per cycle.
- Requester 2: the host/DMA write channel, using a valid/ready handshake.
- The block absorbs the output stream in a small skid FIFO, arbitrates the single memory write port with starvation protection for the host, and reports stream overflow.

Parameters:
ACT_DATA_WIDTH, 8, bits per activation lane
N_LANES, 4, lanes per output beat (mem_wdata = N_LANES*ACT_DATA_WIDTH)
ADDR_WIDTH, 32, memory word address width
FIFO_DEPTH, 4, output-stream skid FIFO entries (power of 2, >=2)
HOST_MAX_WAIT, 8, cycles the host may be starved before it is forced a grant

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ob_en  in  1  output-stream beat valid; no backpressure
ob_word  in  N_LANES*ACT_DATA_WIDTH  output-stream beat data, lane 0 in LSBs
ob_addr  in  ADDR_WIDTH  output-stream beat address
host_valid  in  1  host write request
host_addr  in  ADDR_WIDTH  host write address
host_wdata  in  N_LANES*ACT_DATA_WIDTH  host write data
host_ready  out  1  host beat accepted (combinational, one-cycle pulse)
mem_valid  out  1  memory write request (registered)
mem_addr  out  ADDR_WIDTH  memory write address (registered)
mem_wdata  out  N_LANES*ACT_DATA_WIDTH  memory write data (registered)
mem_ready  in  1  memory accepts the write
overflow_clr  in  1  clears the sticky overflow flag
overflow  out  1  sticky: an output-stream beat was dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  FIFO non-empty or a request is pending

Behaviour:
- Reset values: all outputs 0; FIFO pointers 0; state IDLE; starvation counter 0. Reset mid-transfer discards FIFO contents and the pending request with no completion.
- FIFO push: on ob_en. Pop: when a stream beat is loaded into the mem output register.
- FIFO full at push:
  - if a pop occurs in the same cycle, the push succeeds;
  - otherwise the beat is dropped and overflow is set.
- overflow_clr takes precedence over a set in the same cycle.
- Pointers are ADDR-free, wrap modulo FIFO_DEPTH, and carry one extra bit for full/empty detection.
- FSM states:
  - IDLE: no request outstanding.
  - ISSUE_OB: a stream beat is in the output register.
  - ISSUE_HOST: a host beat is in the output register.
- Load opportunity = state==IDLE, or (mem_valid && mem_ready). This gives back-to-back writes at 1 per cycle.
- Arbitration at each load opportunity:
  - (a) FIFO empty and host_valid: load host beat, host_ready=1, go to ISSUE_HOST.
  - (b) FIFO non-empty, host_valid, starve_cnt>=HOST_MAX_WAIT, and fifo_level<FIFO_DEPTH-1: load host beat.
  - (c) FIFO non-empty otherwise: load FIFO head, pop, go to ISSUE_OB.
  - (d) nothing to load: go to IDLE, mem_valid=0.
- mem_addr and mem_wdata hold stable while mem_valid && !mem_ready.
- starve_cnt:
  - increments (saturating at HOST_MAX_WAIT) on each cycle with host_valid && !host_ready;
  - clears on host_ready or !host_valid.
- Latency: ob_en at edge N → mem_valid at N+2 when the port is free. host_valid in IDLE with FIFO empty → host_ready in the same cycle, mem_valid next cycle.
- busy = (fifo_level!=0) || mem_valid.
- Host data and address are sampled only on the host_ready cycle.

Decomposition:
- Shared package: ACT_DATA_WIDTH, N_LANES, ADDR_WIDTH, the FSM state enum (WB_IDLE, WB_ISSUE_OB, WB_ISSUE_HOST), and a packed beat struct {addr, data}.
- One sub-module: wb_skid_fifo. Parameterised depth, beat struct in/out, push/pop, level, full/empty. The arbiter FSM, starvation counter and output register stay in the top.

Test Plan:
- Stream only, mem_ready=1: 4 ob_en beats addr 0x10..0x13 in consecutive cycles → mem_valid from cycle 2, 4 consecutive writes in order, no overflow, busy drops after the last.
- Memory stall: mem_ready=0 for 10 cycles while 6 beats arrive → beats 1..5 held (1 in register, 4 in FIFO), beat 6 dropped, overflow=1. overflow_clr=1 → overflow=0.
- Host only: host_valid with addr 0x100, data 0xA5A5A5A5, port idle → host_ready same cycle, mem write 0x100/0xA5A5A5A5 next cycle.
- Starvation: continuous ob_en at FIFO level 1, host_valid held, mem_ready=1 → host_ready after exactly 8 waiting cycles, then stream resumes.
- Near-full priority: FIFO level 3 (of 4), host starved 8 cycles → stream beats win until level<3, no overflow.
- Async reset asserted while mem_valid=1 and FIFO level 2 → all outputs 0 immediately, FIFO empty after release.

Source files
------------

// File: rtl/act_wb_arbiter_pkg.sv
// Shared types and sizing for the activation write-back arbiter.
// Beat layout, FSM states and width constants.
package act_wb_arbiter_pkg;

  localparam int ACT_DATA_WIDTH = 8;
  localparam int N_LANES        = 4;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = N_LANES * ACT_DATA_WIDTH;
  localparam int FIFO_DEPTH     = 4;
  localparam int HOST_MAX_WAIT  = 8;
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W       = $clog2(HOST_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ISSUE_OB,
    WB_ISSUE_HOST
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/act_wb_arbiter_if.sv
// Bus bundle of the write-back arbiter: stream, host,
// memory port and status signals.
interface act_wb_if;
  import act_wb_arbiter_pkg::*;

  logic                  ob_en;
  logic [DATA_WIDTH-1:0] ob_word;
  logic [ADDR_WIDTH-1:0] ob_addr;
  logic                  host_valid;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ready;
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  overflow_clr;
  logic                  overflow;
  logic [LVL_W-1:0]      fifo_level;
  logic                  busy;

  modport master (
    output ob_en, ob_word, ob_addr,
    output host_valid, host_addr, host_wdata,
    output mem_ready, overflow_clr,
    input  host_ready, mem_valid, mem_addr,
    input  mem_wdata, overflow, fifo_level, busy
  );

  modport slave (
    input  ob_en, ob_word, ob_addr,
    input  host_valid, host_addr, host_wdata,
    input  mem_ready, overflow_clr,
    output host_ready, mem_valid, mem_addr,
    output mem_wdata, overflow, fifo_level, busy
  );

endinterface

// File: rtl/act_wb_arbiter_wb_skid_fifo.sv
// Skid FIFO for the no-backpressure output stream.
// Pointers carry one extra wrap bit for full/empty.
module wb_skid_fifo
  import act_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  beat_t         din,
  output beat_t         dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   ONE  = 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  beat_t       mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/act_wb_arbiter.sv
// Activation memory write-back arbiter: stream skid FIFO,
// host starvation guard and a registered memory write port.
module act_wb_arbiter
  import act_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  act_wb_if.slave bus
);

  localparam logic [LVL_W-1:0]    NEAR_FULL =
    LVL_W'(FIFO_DEPTH - 1);
  localparam logic [STARVE_W-1:0] MAX_WAIT  =
    STARVE_W'(HOST_MAX_WAIT);
  localparam logic [STARVE_W-1:0] ONE_W     = 1;

  wb_state_t            state;
  beat_t                ob_beat;
  beat_t                head;
  beat_t                out_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic [STARVE_W-1:0]  starve_cnt;
  logic [LVL_W-1:0]     level;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 load_opp;
  logic                 host_pri;
  logic                 grant_host;
  logic                 load_ob;
  logic                 ovf_set;

  assign ob_beat = '{addr: bus.ob_addr, data: bus.ob_word};

  wb_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ob_beat),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // A starved host still yields when the stream is close to dropping.
  always_comb begin
    load_opp   = (state == WB_IDLE) || (valid_q && bus.mem_ready);
    host_pri   = (starve_cnt >= MAX_WAIT) && (level < NEAR_FULL);
    grant_host = reset && load_opp && bus.host_valid
               && (empty || host_pri);
    load_ob    = load_opp && !empty && !grant_host;
    pop        = load_ob;
    push       = bus.ob_en && (!full || pop);
    ovf_set    = bus.ob_en && full && !pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= WB_IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (load_opp) begin
      unique case (1'b1)
        grant_host: begin
          state   <= WB_ISSUE_HOST;
          valid_q <= 1'b1;
          out_q   <= '{addr: bus.host_addr,
                       data: bus.host_wdata};
        end
        load_ob: begin
          state   <= WB_ISSUE_OB;
          valid_q <= 1'b1;
          out_q   <= head;
        end
        default: begin
          state   <= WB_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (bus.overflow_clr) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!bus.host_valid || grant_host) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX_WAIT) begin
      starve_cnt <= starve_cnt + ONE_W;
    end
  end

  assign bus.host_ready = grant_host;
  assign bus.mem_valid  = valid_q;
  assign bus.mem_addr   = out_q.addr;
  assign bus.mem_wdata  = out_q.data;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_level = level;
  assign bus.busy       = (level != '0) || valid_q;

endmodule

// File: tb/tb_act_wb_arbiter.sv
// Bench for act_wb_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_act_wb_arbiter;
  import act_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  act_wb_if bus();

  act_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  logic [63:0] q[$];
  bit          m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  bit          m_ovf;
  int          m_starve;

  function automatic void m_reset();
    q.delete();
    m_valid  = 0;
    m_addr   = 0;
    m_data   = 0;
    m_ovf    = 0;
    m_starve = 0;
  endfunction

  function automatic bit m_opp();
    return !m_valid || bus.mem_ready;
  endfunction

  function automatic bit m_host_go();
    bit pri;
    pri = (m_starve >= HOST_MAX_WAIT)
       && (q.size() < FIFO_DEPTH - 1);
    return m_opp() && bus.host_valid
        && (q.size() == 0 || pri);
  endfunction

  function automatic void m_step();
    bit opp, hg, drop;
    logic [63:0] b;
    opp  = m_opp();
    hg   = m_host_go();
    drop = 0;
    if (hg) begin
      m_valid = 1;
      m_addr  = bus.host_addr;
      m_data  = bus.host_wdata;
    end else if (opp && q.size() > 0) begin
      b       = q.pop_front();
      m_valid = 1;
      m_addr  = b[63:32];
      m_data  = b[31:0];
    end else if (opp) begin
      m_valid = 0;
    end
    if (bus.ob_en) begin
      if (q.size() < FIFO_DEPTH)
        q.push_back({bus.ob_addr, bus.ob_word});
      else
        drop = 1;
    end
    if (bus.overflow_clr) m_ovf = 0;
    else if (drop) m_ovf = 1;
    if (!bus.host_valid || hg) m_starve = 0;
    else if (m_starve < HOST_MAX_WAIT) m_starve++;
  endfunction

  task automatic chk_outputs();
    chk("mem_valid", bus.mem_valid, m_valid);
    if (m_valid) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_data);
    end
    chk("overflow", bus.overflow, m_ovf);
    chk("fifo_level", bus.fifo_level, q.size());
    chk("busy", bus.busy, (q.size() != 0) || m_valid);
  endtask

  task automatic cycle(input bit en,
                       input logic [31:0] oa,
                       input logic [31:0] ow,
                       input bit hv,
                       input logic [31:0] ha,
                       input logic [31:0] hd,
                       input bit mr,
                       input bit clr,
                       output bit hr);
    @(negedge clk);
    bus.ob_en        = en;
    bus.ob_addr      = oa;
    bus.ob_word      = ow;
    bus.host_valid   = hv;
    bus.host_addr    = ha;
    bus.host_wdata   = hd;
    bus.mem_ready    = mr;
    bus.overflow_clr = clr;
    #1;
    hr = bus.host_ready;
    chk("host_ready", hr, m_host_go());
    m_step();
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic idle(input int n, input bit mr);
    bit hr;
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, 0, mr, 0, hr);
  endtask

  initial begin
    bit hr;
    int waits;
    bus.ob_en        = 0;
    bus.ob_addr      = 0;
    bus.ob_word      = 0;
    bus.host_valid   = 0;
    bus.host_addr    = 0;
    bus.host_wdata   = 0;
    bus.mem_ready    = 0;
    bus.overflow_clr = 0;
    m_reset();
    #1;
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_host_ready", bus.host_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Stream only, memory always ready.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h10 + i, 32'hC0DE_0000 + i,
            0, 0, 0, 1, 0, hr);
    idle(3, 1);
    chk("s1_busy_end", bus.busy, 0);

    // Memory stall: sixth beat is dropped.
    for (int i = 0; i < 6; i++)
      cycle(1, 32'h20 + i, 32'hBEEF_0000 + i,
            0, 0, 0, 0, 0, hr);
    idle(4, 0);
    chk("s2_overflow", bus.overflow, 1);
    chk("s2_level", bus.fifo_level, 4);
    chk("s2_held_addr", bus.mem_addr, 32'h20);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, hr);
    chk("s2_clr", bus.overflow, 0);
    idle(8, 1);

    // Host only on an idle port.
    cycle(0, 0, 0, 1, 32'h100, 32'hA5A5_A5A5, 1, 0, hr);
    chk("s3_ready", hr, 1);
    chk("s3_addr", bus.mem_addr, 32'h100);
    chk("s3_data", bus.mem_wdata, 32'hA5A5_A5A5);
    idle(2, 1);

    // Starvation guard with a steady stream.
    cycle(1, 32'h40, 32'h4000, 0, 0, 0, 1, 0, hr);
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 32'h41 + k, 32'h4100 + k,
            1, 32'h200, 32'h5555_AAAA, 1, 0, hr);
      if (hr) break;
      waits++;
    end
    chk("s4_waits", waits, HOST_MAX_WAIT);
    chk("s4_host_addr", bus.mem_addr, 32'h200);
    cycle(1, 32'h60, 32'h6000, 0, 0, 0, 1, 0, hr);
    chk("s4_resume", bus.mem_addr[31:8], 0);
    idle(6, 1);

    // Near-full FIFO keeps priority over a starved host.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h60 + i, 32'h6600 + i,
            0, 0, 0, 0, 0, hr);
    for (int i = 0; i < 9; i++)
      cycle(0, 0, 0, 1, 32'h300, 32'h3333, 0, 0, hr);
    chk("s5_level3", bus.fifo_level, 3);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h70 + i, 32'h7700 + i,
            1, 32'h300, 32'h3333, 1, 0, hr);
      chk("s5_stream_wins", hr, 0);
    end
    cycle(0, 0, 0, 1, 32'h300, 32'h3333, 1, 0, hr);
    chk("s5_pop", hr, 0);
    cycle(0, 0, 0, 1, 32'h300, 32'h3333, 1, 0, hr);
    chk("s5_host_wins", hr, 1);
    chk("s5_no_ovf", bus.overflow, 0);
    idle(6, 1);

    // Asynchronous reset mid-transfer.
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h80 + i, 32'h8800 + i,
            0, 0, 0, 0, 0, hr);
    chk("s6_pre_level", bus.fifo_level, 2);
    chk("s6_pre_valid", bus.mem_valid, 1);
    @(negedge clk);
    bus.ob_en      = 0;
    bus.host_valid = 1;
    #2 reset = 1'b0;
    #1;
    chk("s6_mem_valid", bus.mem_valid, 0);
    chk("s6_level", bus.fifo_level, 0);
    chk("s6_busy", bus.busy, 0);
    chk("s6_host_ready", bus.host_ready, 0);
    chk("s6_mem_addr", bus.mem_addr, 0);
    chk("s6_mem_wdata", bus.mem_wdata, 0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.host_valid = 0;
    idle(2, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 9) < 4), $urandom, $urandom,
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 15) == 0), hr);
    idle(10, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
